// File: rtl/round_loop_ctrl_if.sv
// Handshake/bus bundle for round_loop_ctrl: configuration, fetch PC and loop outputs.
// The abort input exists only when ROUND_LOOP_ABORT_EN is defined.
interface round_loop_ctrl_if #(
   parameter int PC_W  = 64,
   parameter int RND_W = 5
);
   logic             cfg_valid;
   logic [PC_W-1:0]  cfg_start_pc;
   logic [PC_W-1:0]  cfg_end_pc;
   logic [RND_W-1:0] cfg_rounds;
   logic             cfg_ready;
   logic [PC_W-1:0]  PC;
   logic             stall;
   logic             branchTaken;
   logic [PC_W-1:0]  branchOffset;
   logic [RND_W-1:0] round;
   logic             busy;
   logic             done;
`ifdef ROUND_LOOP_ABORT_EN
   logic             abort;

   modport master (
      output cfg_valid, cfg_start_pc, cfg_end_pc, cfg_rounds, PC, stall, abort,
      input  cfg_ready, branchTaken, branchOffset, round, busy, done
   );
   modport slave (
      input  cfg_valid, cfg_start_pc, cfg_end_pc, cfg_rounds, PC, stall, abort,
      output cfg_ready, branchTaken, branchOffset, round, busy, done
   );
`else
   modport master (
      output cfg_valid, cfg_start_pc, cfg_end_pc, cfg_rounds, PC, stall,
      input  cfg_ready, branchTaken, branchOffset, round, busy, done
   );
   modport slave (
      input  cfg_valid, cfg_start_pc, cfg_end_pc, cfg_rounds, PC, stall,
      output cfg_ready, branchTaken, branchOffset, round, busy, done
   );
`endif
endinterface

// File: rtl/round_loop_ctrl.sv
// Hardware round-loop sequencer: branch redirect is combinational (0-cycle), round/busy/done/cfg_ready registered (1-cycle).
// stall freezes all PC matching; cfg_valid is dropped while busy (cfg_ready=0). ROUND_LOOP_ABORT_EN adds an abort input.
module round_loop_ctrl #(
   parameter int PC_W  = 64,
   parameter int RND_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   round_loop_ctrl_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  start_pc_q, start_pc_d;
   logic [PC_W-1:0]  end_pc_q, end_pc_d;
   logic [RND_W-1:0] rounds_q, rounds_d;
   logic [RND_W-1:0] round_q, round_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cfg_ready_q, cfg_ready_d;

   logic             cfg_take;
   logic             start_hit;
   logic             end_hit;
   logic             end_match;
   logic             last_round;
   logic             abort_act;
   logic             branch_taken;
   logic [PC_W-1:0]  branch_offset;

   assign cfg_take   = bus.cfg_valid && (bus.cfg_rounds != '0) &&
                       ((state_q == IDLE) || (state_q == DONE));
   assign start_hit  = !bus.stall && (bus.PC == start_pc_q);
   assign end_hit    = !bus.stall && (bus.PC == end_pc_q);
   // A single-instruction body hits start and end together while still ARMED.
   assign end_match  = end_hit && ((state_q == RUN) || ((state_q == ARMED) && start_hit));
   assign last_round = (round_q == (rounds_q - RND_W'(1)));

`ifdef ROUND_LOOP_ABORT_EN
   assign abort_act  = bus.abort && ((state_q == ARMED) || (state_q == RUN));
`else
   assign abort_act  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         start_pc_q  <= '0;
         end_pc_q    <= '0;
         rounds_q    <= '0;
         round_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         start_pc_q  <= start_pc_d;
         end_pc_q    <= end_pc_d;
         rounds_q    <= rounds_d;
         round_q     <= round_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      start_pc_d = start_pc_q;
      end_pc_d   = end_pc_q;
      rounds_d   = rounds_q;
      if (cfg_take) begin
         state_d    = ARMED;
         start_pc_d = bus.cfg_start_pc;
         end_pc_d   = bus.cfg_end_pc;
         rounds_d   = bus.cfg_rounds;
      end else if (abort_act) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            ARMED: if (start_hit) state_d = (end_match && last_round) ? DONE : RUN;
            RUN:   if (end_match && last_round) state_d = DONE;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      round_d = round_q;
      if (cfg_take || abort_act) begin
         round_d = '0;
      end else if (end_match && !last_round) begin
         round_d = round_q + RND_W'(1);
      end
      done_d        = end_match && last_round && !abort_act;
      busy_d        = (state_d == ARMED) || (state_d == RUN);
      cfg_ready_d   = !busy_d;
      // Reset drops any redirect that would otherwise go out this cycle.
      branch_taken  = !reset && end_match && !last_round && !abort_act;
      branch_offset = branch_taken ? (start_pc_q - end_pc_q) : '0;
   end

   assign bus.branchTaken  = branch_taken;
   assign bus.branchOffset = branch_offset;
   assign bus.round        = round_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.cfg_ready    = cfg_ready_q;
endmodule

// File: tb/tb_round_loop_ctrl.sv
// Directed-vector bench for round_loop_ctrl with an expectation queue drained by a negedge monitor.
module tb_round_loop_ctrl;
   localparam logic [63:0] OFF_C = 64'hFFFF_FFFF_FFFF_FFF4;
   localparam logic [63:0] OFF_8 = 64'hFFFF_FFFF_FFFF_FFF8;

   logic clk = 1'b0;
   logic reset;
   logic abort_req;

   always #5 clk = ~clk;

   round_loop_ctrl_if #(.PC_W(64), .RND_W(5)) bus ();

`ifdef ROUND_LOOP_ABORT_EN
   assign bus.abort = abort_req;
`endif

   round_loop_ctrl #(.PC_W(64), .RND_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        bt;
      logic [63:0] off;
      logic [4:0]  rnd;
      logic        busy;
      logic        done;
      logic        rdy;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   // Monitor: one expected vector per driven cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         logic [72:0] got, want;
         e    = exp_q.pop_front();
         got  = {bus.branchTaken, bus.branchOffset, bus.round, bus.busy, bus.done, bus.cfg_ready};
         want = {e.bt, e.off, e.rnd, e.busy, e.done, e.rdy};
         n_checks++;
         if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got bt=%b off=%h rnd=%0d busy=%b done=%b rdy=%b, want bt=%b off=%h rnd=%0d busy=%b done=%b rdy=%b",
                     e.tag, bus.branchTaken, bus.branchOffset, bus.round, bus.busy, bus.done, bus.cfg_ready,
                     e.bt, e.off, e.rnd, e.busy, e.done, e.rdy);
         end
      end
   end

   task automatic cyc(input logic rst, input logic cv, input logic [63:0] cs, input logic [63:0] ce,
                      input logic [4:0] cr, input logic [63:0] pc, input logic st, input logic ab,
                      input logic bt, input logic [63:0] off, input logic [4:0] rnd,
                      input logic bsy, input logic dn, input logic rdy, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      reset            = rst;
      bus.cfg_valid    = cv;
      bus.cfg_start_pc = cs;
      bus.cfg_end_pc   = ce;
      bus.cfg_rounds   = cr;
      bus.PC           = pc;
      bus.stall        = st;
      abort_req        = ab;
      e.bt = bt; e.off = off; e.rnd = rnd; e.busy = bsy; e.done = dn; e.rdy = rdy; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic run(input logic [63:0] pc, input logic st, input logic bt, input logic [63:0] off,
                      input logic [4:0] rnd, input logic bsy, input logic dn, input logic rdy, input string tag);
      cyc(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, pc, st, 1'b0, bt, off, rnd, bsy, dn, rdy, tag);
   endtask

   task automatic cfg(input logic [63:0] cs, input logic [63:0] ce, input logic [4:0] cr, input logic [63:0] pc,
                      input logic [4:0] rnd, input logic bsy, input logic rdy, input string tag);
      cyc(1'b0, 1'b1, cs, ce, cr, pc, 1'b0, 1'b0, 1'b0, 64'h0, rnd, bsy, 1'b0, rdy, tag);
   endtask

   initial begin
      reset = 1'b1; abort_req = 1'b0;
      bus.cfg_valid = 1'b0; bus.cfg_start_pc = '0; bus.cfg_end_pc = '0; bus.cfg_rounds = '0;
      bus.PC = '0; bus.stall = 1'b0;

      cyc(1'b1, 1'b0, 64'h0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1, "reset_state");

      // Basic loop: 3 passes over 0x100..0x10C
      cfg(64'h100, 64'h10C, 5'd3, 64'h0, 5'd0, 1'b0, 1'b1, "basic_cfg");
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 4; k++) begin
            run(64'h100 + 64'(4 * k), 1'b0, (k == 3 && p < 2), (k == 3 && p < 2) ? OFF_C : 64'h0,
                5'(p), 1'b1, 1'b0, 1'b0, (k == 3) ? "basic_end" : "basic_body");
         end
      end
      run(64'h110, 1'b0, 1'b0, 64'h0, 5'd2, 1'b0, 1'b1, 1'b1, "basic_done_pulse");
      run(64'h114, 1'b0, 1'b0, 64'h0, 5'd2, 1'b0, 1'b0, 1'b1, "basic_done_clear");

      // Stall held at end PC
      cfg(64'h300, 64'h308, 5'd2, 64'h0, 5'd2, 1'b0, 1'b1, "stall_cfg");
      run(64'h300, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, "stall_entry");
      run(64'h304, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, "stall_body");
      for (int i = 0; i < 3; i++)
         run(64'h308, 1'b1, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, "stall_held");
      run(64'h308, 1'b0, 1'b1, OFF_8, 5'd0, 1'b1, 1'b0, 1'b0, "stall_release_branch");
      run(64'h300, 1'b0, 1'b0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, "stall_round1");
      run(64'h304, 1'b0, 1'b0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, "stall_round1_body");
      run(64'h308, 1'b0, 1'b0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, "stall_last_fallthru");
      run(64'h30C, 1'b0, 1'b0, 64'h0, 5'd1, 1'b0, 1'b1, 1'b1, "stall_done");

      // Single-instruction body, one round
      cfg(64'h200, 64'h200, 5'd1, 64'h0, 5'd1, 1'b0, 1'b1, "single_cfg");
      run(64'h200, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, "single_match_nobranch");
      run(64'h204, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b1, 1'b1, "single_done");
      run(64'h208, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1, "single_done_clear");

      // Zero rounds ignored in IDLE; reconfiguration ignored while busy
      cyc(1'b1, 1'b0, 64'h0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1, "zero_reset");
      cfg(64'h400, 64'h404, 5'd0, 64'h0, 5'd0, 1'b0, 1'b1, "zero_cfg");
      run(64'h400, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1, "zero_ignored");
      run(64'h404, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1, "zero_no_match");
      cfg(64'h400, 64'h408, 5'd2, 64'h0, 5'd0, 1'b0, 1'b1, "busy_cfg");
      run(64'h400, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, "busy_entry");
      cfg(64'h500, 64'h504, 5'd5, 64'h404, 5'd0, 1'b1, 1'b0, "busy_reconfig");
      run(64'h504, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, "busy_new_end_ignored");
      run(64'h408, 1'b0, 1'b1, OFF_8, 5'd0, 1'b1, 1'b0, 1'b0, "busy_orig_branch");
      run(64'h400, 1'b0, 1'b0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, "busy_round1");
      run(64'h404, 1'b0, 1'b0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, "busy_round1_body");
      run(64'h408, 1'b0, 1'b0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, "busy_last");
      run(64'h40C, 1'b0, 1'b0, 64'h0, 5'd1, 1'b0, 1'b1, 1'b1, "busy_done");

      // Reset mid-loop at end PC in round 1
      cfg(64'h600, 64'h608, 5'd3, 64'h0, 5'd1, 1'b0, 1'b1, "rst_cfg");
      run(64'h600, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, "rst_entry");
      run(64'h608, 1'b0, 1'b1, OFF_8, 5'd0, 1'b1, 1'b0, 1'b0, "rst_branch0");
      run(64'h600, 1'b0, 1'b0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, "rst_round1");
      cyc(1'b1, 1'b0, 64'h0, 64'h0, 5'd0, 64'h608, 1'b0, 1'b0, 1'b0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, "rst_cycle_dropped");
      run(64'h608, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1, "rst_after_idle");

`ifdef ROUND_LOOP_ABORT_EN
      cfg(64'h700, 64'h70C, 5'd4, 64'h0, 5'd0, 1'b0, 1'b1, "abort_cfg");
      run(64'h700, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, "abort_entry");
      run(64'h704, 1'b0, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, "abort_body");
      cyc(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 64'h70C, 1'b0, 1'b1, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, "abort_over_end");
      run(64'h710, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1, "abort_idle");
      cyc(1'b0, 1'b1, 64'h700, 64'h70C, 5'd4, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1, "abort_in_idle_cfg");
      cyc(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, "abort_idle_noeffect");
      run(64'h0, 1'b0, 1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1, "abort_from_armed");
`endif

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
